ram_stream_reader_512x32: RTL



---
 rtl/ram_stream_reader_512x32_pkg.sv | 34 +++
 rtl/ram_stream_reader_512x32_if.sv | 40 ++++
 rtl/ram_stream_reader_512x32_skid_fifo.sv | 47 ++++
 rtl/ram_stream_reader_512x32.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_512x32_pkg.sv
// Shared constants, state encoding and FIFO beat layout for the 512x32 RAM read streamer.
// Optional build macro: RAM_RD_PARITY_EN adds a per-beat even-parity bit.
package ram_rd_pkg;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LEN_W      = 10;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned RAM_DEPTH  = 512;
  localparam int unsigned RD_LATENCY = 2;   // issue edge to FIFO capture edge
  localparam int unsigned MAX_LEN    = 512;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // One FIFO entry: RAM word plus the end-of-command tag (and parity when enabled)
  typedef struct packed {
`ifdef RAM_RD_PARITY_EN
    logic              parity;
`endif
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Lengths beyond the RAM depth collapse to one full pass over the RAM
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/ram_stream_reader_512x32_if.sv
// Command, RAM read port and output stream bundle for the RAM read streamer.
// Optional build macro: RAM_RD_PARITY_EN adds m_parity.
interface ram_stream_reader_512x32_if;
  import ram_rd_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;
`ifdef RAM_RD_PARITY_EN
  logic              m_parity;
`endif

  // Reader side
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
    output cmd_ready, ram_read_addr, m_valid, m_data, m_last, busy, done
`ifdef RAM_RD_PARITY_EN
    , output m_parity
`endif
  );

  // Command source, RAM and stream sink side
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
    input  cmd_ready, ram_read_addr, m_valid, m_data, m_last, busy, done
`ifdef RAM_RD_PARITY_EN
    , input m_parity
`endif
  );

endinterface

// File: rtl/ram_stream_reader_512x32_skid_fifo.sv
// Small synchronous skid FIFO that absorbs RAM words issued ahead of downstream accept.
module ram_rd_skid_fifo
  import ram_rd_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  beat_t            push_data,
  input  logic             pop,
  output beat_t            head_c,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  beat_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/ram_stream_reader_512x32.sv
// Read-side controller for a 512x32 RAM: issues addresses under FIFO credit and streams words out.
// Optional build macro: RAM_RD_PARITY_EN adds m_parity carried alongside each beat.
module ram_stream_reader_512x32
  import ram_rd_pkg::*;
(
  input logic                        clock,
  input logic                        reset,
  ram_stream_reader_512x32_if.master bus
);

  state_t                state;
  state_t                state_nxt;
  logic [LEN_W-1:0]      remaining;
  logic [LEN_W-1:0]      remaining_nxt;
  logic [LEN_W-1:0]      len_clamped;
  logic [ADDR_W-1:0]     addr_nxt;
  logic                  cmd_ready_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  issue;
  logic                  issue_last;
  logic [RD_LATENCY-1:0] pipe_v;      // [0]: address on the bus, [1]: word on ram_dout
  logic [RD_LATENCY-1:0] pipe_last;
  logic [1:0]            inflight;
  logic                  credit_ok;
  logic [CNT_W-1:0]      fifo_count;
  logic                  pop;
  beat_t                 push_beat;
  beat_t                 head;

  assign len_clamped = clamp_len(bus.cmd_len);
  assign inflight    = 2'(pipe_v[0]) + 2'(pipe_v[1]);
  assign credit_ok   = ((CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(FIFO_DEPTH);
  assign pop         = bus.m_valid && bus.m_ready;

  // Next-state, address issue and registered-output next values
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    addr_nxt      = bus.ram_read_addr;
    cmd_ready_nxt = bus.cmd_ready;
    busy_nxt      = bus.busy;
    done_nxt      = 1'b0;
    issue         = 1'b0;
    issue_last    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (len_clamped == '0) begin
            done_nxt = 1'b1;
          end else begin
            issue         = 1'b1;
            issue_last    = (len_clamped == LEN_W'(1));
            addr_nxt      = bus.cmd_addr;
            remaining_nxt = len_clamped - LEN_W'(1);
            cmd_ready_nxt = 1'b0;
            busy_nxt      = 1'b1;
            state_nxt     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if ((remaining != '0) && credit_ok) begin
          issue         = 1'b1;
          issue_last    = (remaining == LEN_W'(1));
          addr_nxt      = bus.ram_read_addr + ADDR_W'(1);
          remaining_nxt = remaining - LEN_W'(1);
        end
        if (remaining_nxt == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((inflight == 2'd0) && pop && head.last) begin
          done_nxt      = 1'b1;
          cmd_ready_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, command bookkeeping and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      remaining         <= '0;
      bus.ram_read_addr <= '0;
      bus.cmd_ready     <= 1'b1;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      state             <= state_nxt;
      remaining         <= remaining_nxt;
      bus.ram_read_addr <= addr_nxt;
      bus.cmd_ready     <= cmd_ready_nxt;
      bus.busy          <= busy_nxt;
      bus.done          <= done_nxt;
    end
  end

  // Tracks issued words through the RAM's registered read to the FIFO capture edge
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      pipe_v    <= {pipe_v[0], issue};
      pipe_last <= {pipe_last[0], issue_last};
    end
  end

  // Beat captured from the RAM output
  always_comb begin
    push_beat      = '0;
    push_beat.data = bus.ram_dout;
    push_beat.last = pipe_last[RD_LATENCY-1];
`ifdef RAM_RD_PARITY_EN
    push_beat.parity = ^bus.ram_dout;
`endif
  end

  ram_rd_skid_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pipe_v[RD_LATENCY-1]),
    .push_data (push_beat),
    .pop       (pop),
    .head_c    (head),
    .count     (fifo_count)
  );

  assign bus.m_valid = (fifo_count != '0);
  assign bus.m_data  = head.data;
  assign bus.m_last  = head.last;
`ifdef RAM_RD_PARITY_EN
  assign bus.m_parity = head.parity;
`endif

endmodule
